pwm_meter: RTL and testbench
============================

// Module: pwm_meter
// PURPOSE
//  Receive-side counterpart of pwm_gen: measures an incoming PWM waveform and reports its
//  duty cycle as an integer percentage (0-100, same encoding as pwm_gen duty_cycle) plus its
//  period in clk cycles. Sits on board-level PWM inputs (fan tach/servo feedback, loopback of
//  pwm_gen). Detects a stuck input (0%/100%) by timeout.
// PARAMETERS
//  CLK_FREQ         50_000_000  system clock frequency, Hz
//  PWM_FREQ         1000        nominal input PWM frequency, Hz; NOM_CYC = CLK_FREQ/PWM_FREQ
//  TIMEOUT_PERIODS  4           no rising edge for TIMEOUT_PERIODS*NOM_CYC cycles => stuck input
//  (derived) TMO_CYC = TIMEOUT_PERIODS*NOM_CYC; CNT_W = $clog2(TMO_CYC+1); NUM_W = CNT_W+7
// PORTS
//  clk            in   1      system clock
//  rst_n          in   1      asynchronous active-low reset
//  pwm_in         in   1      asynchronous PWM input
//  duty_cycle     out  8      last measured duty, percent 0..100, rounded to nearest
//  period_cycles  out  CNT_W  last measured period in clk cycles; 0 when no_signal
//  valid          out  1      1-cycle pulse when duty_cycle/period_cycles update
//  no_signal      out  1      level: input stuck (timeout); cleared by next valid measurement
// BEHAVIOUR
//  Reset: duty_cycle=0, period_cycles=0, valid=0, no_signal=0; sync FFs=0; state S_ARM.
//  Input: 2-FF synchronizer, then edge-detect register; rise/fall are single-cycle strobes.
//  Counters (CNT_W): per_cnt counts every cycle, hi_cnt counts cycles with synced level 1;
//   both saturate at TMO_CYC. On rise: per_cnt<=1, hi_cnt<=1 (edge cycle counts as high).
//  FSM (enum in package):
//   S_ARM  : counters cleared; first rise -> S_MEAS (no result; covers input high at reset).
//   S_MEAS : counting. rise -> latch P=per_cnt, H=hi_cnt, start divider, -> S_DIV.
//            per_cnt reaches TMO_CYC -> timeout (below).
//   S_DIV  : divider busy; counters keep measuring the next period. done -> register outputs,
//            valid=1 for one cycle, no_signal<=0, -> S_MEAS. rise while busy: measurement of
//            that period discarded, counters restart, divider not restarted.
//  Arithmetic: duty = (H*100 + P/2) / P, NUM_W-bit numerator, unsigned; result clamped to 100.
//   P==0 impossible (P>=1). period_cycles <= P.
//  Latency: valid asserts exactly NUM_W+2 clk after the cycle rise is seen (NUM_W divider
//   iterations + start + output register).
//  Timeout (S_MEAS or S_DIV with no rise): per_cnt==TMO_CYC -> no_signal=1, period_cycles=0,
//   duty_cycle = synced level ? 100 : 0, valid pulse once, -> S_ARM. An in-flight division is
//   abandoned. Stays in S_ARM (no repeat pulses) until next rise.
//  Periods above TMO_CYC are reported as stuck, never as measurement.
//  Reset mid-operation: all state cleared asynchronously, divider aborted, outputs to reset values.
// STRUCTURE
//  pwm_pkg: state_t {S_ARM,S_MEAS,S_DIV}; function for CNT_W/NUM_W derivation; PCT_MAX=100.
//  Sub-module pwm_div: sequential restoring divider, parameter W; ports clk,rst_n,start,
//   num[W-1:0],den[W-1:0],busy,done(1-cycle),quo[W-1:0]; W cycles per division, abort on rst_n.
//  Top: synchronizer, edge detect, counters, FSM, output registers.
// TESTING (CLK_FREQ=50 MHz, PWM_FREQ=1 kHz: NOM_CYC=50000, TMO_CYC=200000; drive via pwm_gen)
//  1. pwm_gen duty 25/50/75, 5 periods each -> valid every 50000 clk, duty_cycle 25/50/75,
//     period_cycles 50000, no_signal=0; first period after reset produces no valid.
//  2. pwm_in held 1 (pwm_gen duty 100 or 110) -> one valid 200000 clk after last rise,
//     no_signal=1, duty_cycle=100, period_cycles=0; no further valid pulses.
//  3. pwm_in held 0 -> no_signal=1, duty_cycle=0; then restart PWM 50% -> no_signal clears
//     with first valid after second rise, duty_cycle=50.
//  4. Rounding: high 12499 of 50000 -> 25; high 1 of 50000 -> 0; high 49999 of 50000 -> 100.
//  5. Period 100000 cycles (500 Hz, 30%) -> period_cycles 100000, duty 30; 250000 cycles -> timeout.
//  6. rst_n pulse mid-S_DIV -> outputs 0 at once, no valid from aborted division, re-arm on next rise.

Source files
------------

// File: rtl/pwm_meter_pkg.sv
// Shared types and width helpers for the PWM duty/period meter.
package pwm_pkg;

  // Duty is reported as an integer percentage.
  localparam int PCT_MAX = 100;

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,  // waiting for the first rising edge
    S_MEAS = 2'd1,  // counting the current period
    S_DIV  = 2'd2   // divider busy with the last period
  } state_t;

  // Counter width that can hold the timeout value itself.
  function automatic int cnt_width(input int tmo_cyc);
    return $clog2(tmo_cyc + 1);
  endfunction

  // The numerator H*100 + P/2 is below TMO_CYC*128, so seven extra bits suffice.
  function automatic int num_width(input int cnt_w);
    return cnt_w + 7;
  endfunction

endpackage

// File: rtl/pwm_meter_div.sv
// Sequential restoring divider: one quotient bit per clock, W clocks per division.
module pwm_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quo
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  q_sh;
  logic [W-1:0]  den_q;
  logic [CW-1:0] cnt;
  logic [W:0]    rem_sh;
  logic [W:0]    diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // A set MSB in diff means the subtraction borrowed.
  assign rem_sh = {rem, q_sh[W-1]};
  assign diff   = rem_sh - {1'b0, den_q};
  assign quo    = q_sh;

  // Load on start (restarting any division in flight), then iterate W times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      q_sh  <= '0;
      den_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= '0;
        q_sh  <= num;
        den_q <= den;
        cnt   <= CW'(W);
        busy  <= 1'b1;
      end else if (busy) begin
        if (!diff[W]) begin
          rem  <= diff[W-1:0];
          q_sh <= {q_sh[W-2:0], 1'b1};
        end else begin
          rem  <= rem_sh[W-1:0];
          q_sh <= {q_sh[W-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_meter.sv
// Measures an incoming PWM waveform: duty in percent and period in clk cycles,
// with stuck-input detection when no rising edge arrives within the timeout.
module pwm_meter
  import pwm_pkg::*;
#(
  parameter  int CLK_FREQ        = 50_000_000,
  parameter  int PWM_FREQ        = 1000,
  parameter  int TIMEOUT_PERIODS = 4,
  localparam int NOM_CYC         = CLK_FREQ / PWM_FREQ,
  localparam int TMO_CYC         = TIMEOUT_PERIODS * NOM_CYC,
  localparam int CNT_W           = cnt_width(TMO_CYC),
  localparam int NUM_W           = num_width(CNT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [7:0]       duty_cycle,
  output logic [CNT_W-1:0] period_cycles,
  output logic             valid,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TMO_CYC);

  logic             sync1, sync2, level_q;
  logic             level, rise;
  logic [CNT_W-1:0] per_cnt, hi_cnt, p_lat;
  state_t           state;
  logic             timeout;
  logic             div_start, div_busy, div_done;
  logic [NUM_W-1:0] div_num, div_den, div_quo;

  // Two-flop synchronizer followed by the edge-detect register.
  // NOTE: every flop in a clocked block uses <= so all of them sample the
  // pre-edge values; with = the chain would collapse into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1   <= pwm_in;
      sync2   <= sync1;
      level_q <= sync2;
    end
  end

  assign level   = sync2;
  assign rise    = sync2 & ~level_q;
  assign timeout = (state != S_ARM) && (per_cnt == TMO_CNT) && !rise;

  // Period and high-time counters; the rising-edge cycle is the first high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else if (state == S_ARM) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      if (per_cnt != TMO_CNT) per_cnt <= per_cnt + CNT_W'(1);
      if (level && hi_cnt != TMO_CNT) hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  // Division starts in the rise cycle straight from the live counters:
  // duty = (H*100 + P/2) / P rounds to nearest.
  assign div_start = (state == S_MEAS) && rise;
  assign div_num   = NUM_W'(hi_cnt) * NUM_W'(PCT_MAX) + NUM_W'(per_cnt >> 1);
  assign div_den   = NUM_W'(per_cnt);

  pwm_div #(.W(NUM_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // Measurement FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_ARM;
      p_lat         <= '0;
      duty_cycle    <= '0;
      period_cycles <= '0;
      valid         <= 1'b0;
      no_signal     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (timeout) begin
        // Stuck input: report the held level; any division in flight is dropped.
        duty_cycle    <= level ? 8'(PCT_MAX) : 8'd0;
        period_cycles <= '0;
        no_signal     <= 1'b1;
        valid         <= 1'b1;
        state         <= S_ARM;
      end else begin
        case (state)
          S_ARM: begin
            // The first edge only opens a period; nothing to report yet.
            if (rise) state <= S_MEAS;
          end
          S_MEAS: begin
            if (rise) begin
              p_lat <= per_cnt;
              state <= S_DIV;
            end
          end
          S_DIV: begin
            // Edges arriving here only restart the counters; the divider
            // keeps working on the period it already has.
            if (div_done) begin
              duty_cycle    <= (div_quo > NUM_W'(PCT_MAX)) ? 8'(PCT_MAX) : div_quo[7:0];
              period_cycles <= p_lat;
              no_signal     <= 1'b0;
              valid         <= 1'b1;
              state         <= S_MEAS;
            end else if (!div_busy) begin
              // Divider idle without a result: resume measuring rather than wait forever.
              state <= S_MEAS;
            end
          end
          default: state <= S_ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter with a scaled-down clock ratio:
// NOM_CYC=100, TMO_CYC=400, CNT_W=9, NUM_W=16.
module tb_pwm_meter;

  localparam int TMO   = 400;
  localparam int CNT_W = 9;
  localparam int LAT   = 20;       // drive edge -> valid: 2 sync + NUM_W + 2
  localparam int TLAT  = TMO + 3;  // last rise drive -> timeout valid

  typedef struct {
    int duty;
    int period;
    int nosig;
    int due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [7:0]       duty_cycle;
  logic [CNT_W-1:0] period_cycles;
  logic             valid;
  logic             no_signal;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   have_prev;
  int   prev_p, prev_duty, last_rise;

  pwm_meter #(
    .CLK_FREQ        (100_000),
    .PWM_FREQ        (1000),
    .TIMEOUT_PERIODS (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_in        (pwm_in),
    .duty_cycle    (duty_cycle),
    .period_cycles (period_cycles),
    .valid         (valid),
    .no_signal     (no_signal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid with duty %0d period %0d at cycle %0d, expected none",
                 duty_cycle, period_cycles, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("duty_cycle", int'(duty_cycle), e.duty);
        check("period_cycles", int'(period_cycles), e.period);
        check("no_signal", int'(no_signal), e.nosig);
        check("valid_cycle", cyc, e.due);
      end
    end
  end

  // A rising edge closes the previous period, whose result is then due.
  task automatic rise_event();
    if (have_prev) exp_q.push_back('{prev_duty, prev_p, 0, cyc + LAT});
    last_rise = cyc;
  endtask

  // One PWM period: h cycles high, p-h low; d is the hand-computed duty.
  task automatic pwm_period(input int h, input int p, input int d);
    rise_event();
    if (p > TMO) exp_q.push_back('{(h > TMO) ? 100 : 0, 0, 1, last_rise + TLAT});
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
    have_prev = (p <= TMO);
    prev_p    = p;
    prev_duty = d;
  endtask

  task automatic hold_high();
    rise_event();
    exp_q.push_back('{100, 0, 1, last_rise + TLAT});
    pwm_in = 1'b1;
    repeat (TMO + 60) @(negedge clk);
    check("no_signal_held_high", int'(no_signal), 1);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    have_prev = 1'b0;
  endtask

  task automatic hold_low();
    exp_q.push_back('{0, 0, 1, last_rise + TLAT});
    repeat (TMO + 60) @(negedge clk);
    check("no_signal_held_low", int'(no_signal), 1);
    have_prev = 1'b0;
  endtask

  initial begin
    pwm_in    = 1'b0;
    rst_n     = 1'b0;
    have_prev = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty_cycle), 0);
    check("rst_period", int'(period_cycles), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_no_signal", int'(no_signal), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Steady trains at 25/50/75 %; the first period after reset yields nothing.
    for (int i = 0; i < 5; i++) pwm_period(25, 100, 25);
    for (int i = 0; i < 5; i++) pwm_period(50, 100, 50);
    for (int i = 0; i < 5; i++) pwm_period(75, 100, 75);
    hold_high();

    // Stuck low, then restart: no_signal clears with the first real result.
    pwm_period(50, 100, 50);
    pwm_period(50, 100, 50);
    hold_low();
    pwm_period(50, 100, 50);
    pwm_period(50, 100, 50);

    // Rounding and period boundaries.
    pwm_period(49, 200, 25);    // (4900+100)/200   = 25
    pwm_period(1, 399, 0);      // (100+199)/399    = 0
    pwm_period(398, 399, 100);  // (39800+199)/399  = 100
    pwm_period(397, 399, 99);   // (39700+199)/399  = 99
    pwm_period(60, 200, 30);    // (6000+100)/200   = 30
    pwm_period(150, 500, 0);    // longer than timeout: stuck-low report

    // Reset while the divider is busy.
    pwm_period(50, 100, 50);
    pwm_period(50, 100, 50);
    have_prev = 1'b0;           // this rise's division gets aborted
    rise_event();
    pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    pwm_in = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_duty", int'(duty_cycle), 0);
    check("midrst_period", int'(period_cycles), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_no_signal", int'(no_signal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (90) @(negedge clk);
    pwm_period(50, 100, 50);
    pwm_period(50, 100, 50);
    hold_high();

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
